// File: rtl/display_buffer_sequencer_if.sv
// rtl/display_buffer_sequencer_if.sv - CPU command, scanner read and RAM port bundle
// The sequencer uses the slave modport; the environment driving it uses master.
interface display_buffer_sequencer_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic [7:0]        cpu_ctrl;
  logic              cpu_busy;

  logic              scan_req;
  logic [ADDR_W-1:0] scan_addr;
  logic              scan_gnt;
  logic [DATA_W-1:0] scan_rdata;
  logic              scan_rvalid;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_addr, cpu_data, cpu_ctrl, scan_req, scan_addr, mem_rdata,
    output cpu_busy, scan_gnt, scan_rdata, scan_rvalid, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output cpu_addr, cpu_data, cpu_ctrl, scan_req, scan_addr, mem_rdata,
    input  cpu_busy, scan_gnt, scan_rdata, scan_rvalid, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/display_buffer_sequencer.sv
// rtl/display_buffer_sequencer.sv - LED display buffer RAM owner: scanner/CPU arbitration and hardware fill
// Scanner reads win, except when the CPU side has waited through STARVE_MAX scanner grants.
module display_buffer_sequencer #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic                        clk,
  input logic                        reset,
  display_buffer_sequencer_if.slave  bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e            state_q, state_d;
  logic [1:0]        ctrl_q;
  logic              pend_v_q, pend_v_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              rvalid_q;

  logic wr_tog, clr_tog, clearing, cpu_wait, starved, idle_free;
  logic scan_win, cpu_win, scan_gnt;
  logic unused_ctrl;

  assign unused_ctrl = ^bus.cpu_ctrl[7:2];

  assign wr_tog    = bus.cpu_ctrl[0] ^ ctrl_q[0];
  assign clr_tog   = bus.cpu_ctrl[1] ^ ctrl_q[1];
  assign clearing  = (state_q == ST_CLEAR);
  assign cpu_wait  = pend_v_q | clearing;
  assign idle_free = !pend_v_q && !clearing;
  assign starved   = cpu_wait && (starve_q == STARVE_LIM);
  assign scan_win  = bus.scan_req && !starved;
  assign cpu_win   = !scan_win && cpu_wait;
  assign scan_gnt  = scan_win && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= bus.cpu_ctrl[1:0];
      pend_v_q  <= 1'b0;
      clr_cnt_q <= '0;
      starve_q  <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= bus.cpu_ctrl[1:0];
      pend_v_q  <= pend_v_d;
      clr_cnt_q <= clr_cnt_d;
      starve_q  <= starve_d;
      rvalid_q  <= scan_gnt;
    end
  end

  always_ff @(posedge clk) begin
    pend_addr_q <= pend_addr_d;
    pend_data_q <= pend_data_d;
    fill_q      <= fill_d;
  end

  // A write toggle takes precedence, so a simultaneous clear toggle never starts a fill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (clr_tog && !wr_tog && idle_free) state_d = ST_CLEAR;
      ST_CLEAR: if (cpu_win && clr_cnt_q == LAST_ADDR) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    fill_d      = fill_q;
    clr_cnt_d   = clr_cnt_q;
    starve_d    = '0;

    if (pend_v_q && cpu_win) begin
      pend_v_d = 1'b0;
    end else if (wr_tog && idle_free) begin
      pend_v_d    = 1'b1;
      pend_addr_d = bus.cpu_addr;
      pend_data_d = bus.cpu_data;
    end

    if (clr_tog && !wr_tog && idle_free) begin
      fill_d    = bus.cpu_data;
      clr_cnt_d = '0;
    end else if (clearing && cpu_win) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
    end

    if (scan_win && cpu_wait) begin
      starve_d = starved ? starve_q : starve_q + CNT_W'(1);
    end
  end

  // Every visible strobe is gated by reset so an aborted fill stops in the reset cycle itself.
  always_comb begin
    bus.scan_gnt    = scan_gnt;
    bus.mem_we      = cpu_win && !reset;
    bus.mem_addr    = cpu_win ? (pend_v_q ? pend_addr_q : clr_cnt_q) : bus.scan_addr;
    bus.mem_wdata   = pend_v_q ? pend_data_q : fill_q;
    bus.cpu_busy    = cpu_wait && !reset;
    bus.scan_rvalid = rvalid_q && !reset;
    bus.scan_rdata  = bus.mem_rdata;
  end
endmodule
